// File: rtl/slice_key_detector.sv
// Slice key front end: synchronises, debounces and turns each accepted key press into one slice pulse.
// Optional auto-repeat while the key is held is enabled by defining SLICE_AUTOREPEAT_EN.
module slice_key_detector #(
   parameter int DEBOUNCE_CYC   = 500000,
   parameter int CNT_W          = 20,
   parameter bit KEY_ACTIVE_LOW = 1'b1,
   parameter int REPEAT_CYC     = 25000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en_i,
   input  logic       key_i,
   output logic       slice_o,
   output logic       pressed_o,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARM     = 3'd1,
      S_FIRE    = 3'd2,
      S_HELD    = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   localparam logic             KEY_RELEASED = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;
   localparam logic [CNT_W-1:0] DEB_LAST     = CNT_W'(DEBOUNCE_CYC - 1);

   if (DEBOUNCE_CYC < 2 || REPEAT_CYC < 1 ||
       (longint'(1) << CNT_W) <= longint'(DEBOUNCE_CYC)) begin : g_bad_params
      $error("slice_key_detector: DEBOUNCE_CYC/REPEAT_CYC out of range for CNT_W");
   end

`ifdef SLICE_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYC - 1);

   if ((longint'(1) << CNT_W) <= longint'(REPEAT_CYC)) begin : g_bad_repeat
      $error("slice_key_detector: CNT_W too narrow for REPEAT_CYC");
   end
`endif

   logic             r_sync1;
   logic             r_sync2;
   logic             w_key_s;
   state_t           r_state;
   state_t           w_state_nx;
   logic [CNT_W-1:0] r_cnt;
   logic             w_cnt_inc;

   // Synchroniser flops come out of reset at the released level so reset never looks like a press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= KEY_RELEASED;
         r_sync2 <= KEY_RELEASED;
      end else begin
         // NOTE: non-blocking assignments make r_sync2 take the old r_sync1, giving two real flop stages.
         r_sync1 <= key_i;
         r_sync2 <= r_sync1;
      end
   end

   assign w_key_s = (r_sync2 != KEY_RELEASED);

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      w_state_nx = r_state;
      w_cnt_inc  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_key_s) w_state_nx = S_ARM;
         end
         S_ARM: begin
            if (!w_key_s)              w_state_nx = S_IDLE;
            else if (r_cnt == DEB_LAST) w_state_nx = S_FIRE;
            else                       w_cnt_inc  = 1'b1;
         end
         S_FIRE: begin
            w_state_nx = S_HELD;
         end
         S_HELD: begin
`ifdef SLICE_AUTOREPEAT_EN
            if (!w_key_s)              w_state_nx = S_RELEASE;
            else if (r_cnt == REP_LAST) w_state_nx = S_FIRE;
            else                       w_cnt_inc  = 1'b1;
`else
            if (!w_key_s) w_state_nx = S_RELEASE;
`endif
         end
         S_RELEASE: begin
            if (w_key_s)               w_state_nx = S_HELD;
            else if (r_cnt == DEB_LAST) w_state_nx = S_IDLE;
            else                       w_cnt_inc  = 1'b1;
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // Every state change restarts the count, so the counter never has to wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         if (w_state_nx != r_state) r_cnt <= '0;
         else if (w_cnt_inc)        r_cnt <= r_cnt + 1'b1;
      end
   end

   assign slice_o   = (r_state == S_FIRE) & en_i;
   assign pressed_o = (r_state == S_FIRE) | (r_state == S_HELD) | (r_state == S_RELEASE);
   assign state_o   = r_state;

endmodule
